// File: rtl/i2s_rx_sync_pkg.sv
// Shared definitions for the I2S receive path.
//  - state_e : deserialiser FSM states
//  - CH_L/CH_R : channel encoding, which matches the lrclk level (0 = left, 1 = right)
//  - is_left_start : detects the lrclk 1->0 transition that opens a stereo frame
package i2s_rx_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  function automatic logic is_left_start(input logic lr_prev, input logic lr_now);
    return lr_prev & ~lr_now;
  endfunction

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Synchroniser for one asynchronous input, with edge pulses derived from the
// synchronised level.
//  clk     in   system clock
//  rst_n   in   asynchronous active-low reset
//  async_i in   asynchronous input
//  level_o out  synchronised level (SYNC_STAGES flops after the pin)
//  rise_o  out  one-clk pulse: level_o is 1 and was 0 in the previous cycle
//  fall_o  out  one-clk pulse: level_o is 0 and was 1 in the previous cycle
module i2s_rx_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edges are combinational on the last stage so they add no latency beyond
  // the synchroniser itself.
  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/i2s_rx_sync.sv
// Single-clock I2S receiver. bclk, lrclk and sdata are oversampled in the clk
// domain; each stereo frame is deserialised MSB-first into BITSIZE-bit words.
//  clk        in   system clock (>= 8x bclk)
//  reset      in   asynchronous active-low reset
//  bclk       in   codec bit clock, sampled as data
//  lrclk      in   codec LR clock, 0 = left, 1 = right
//  sdata      in   codec serial data
//  left_chan  out  last complete left word (held between frames)
//  right_chan out  last complete right word (held between frames)
//  valid      out  one-clk pulse when left_chan/right_chan update together
//  frame_err  out  one-clk pulse when a word is cut short by an LR change
module i2s_rx_sync
  import i2s_rx_sync_pkg::*;
#(
  parameter int BITSIZE     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bclk,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               valid,
  output logic               frame_err
);

  localparam int            CW       = $clog2(BITSIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITSIZE - 1);

  // ---------------------------------------------------------------- inputs
  logic bre;
  logic lrclk_s;
  logic sdata_s;
  logic bclk_level_unused;
  logic bclk_fall_unused;
  logic lrclk_rise_unused;
  logic lrclk_fall_unused;
  logic sdata_rise_unused;
  logic sdata_fall_unused;

  // All three inputs share the same depth so lrclk/sdata are aligned with bre.
  i2s_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk     (clk),
    .rst_n   (reset),
    .async_i (bclk),
    .level_o (bclk_level_unused),
    .rise_o  (bre),
    .fall_o  (bclk_fall_unused)
  );

  i2s_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk     (clk),
    .rst_n   (reset),
    .async_i (lrclk),
    .level_o (lrclk_s),
    .rise_o  (lrclk_rise_unused),
    .fall_o  (lrclk_fall_unused)
  );

  i2s_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk     (clk),
    .rst_n   (reset),
    .async_i (sdata),
    .level_o (sdata_s),
    .rise_o  (sdata_rise_unused),
    .fall_o  (sdata_fall_unused)
  );

  // ---------------------------------------------------------------- state
  state_e             state_q,  state_d;
  logic               ch_q,     ch_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [BITSIZE-1:0] shreg_q,  shreg_d;
  logic [BITSIZE-1:0] hold_l_q, hold_l_d;
  logic [BITSIZE-1:0] hold_r_q, hold_r_d;
  logic               bad_q,    bad_d;
  logic               lr_prev_q, lr_prev_d;
  logic               pend_q,   pend_d;
  logic               err_q,    err_d;
  logic [BITSIZE-1:0] left_q,   left_d;
  logic [BITSIZE-1:0] right_q,  right_d;
  logic               valid_q,  valid_d;

  logic               lr_chg;
  logic [BITSIZE-1:0] word;

  assign lr_chg = (lrclk_s != lr_prev_q);
  // Word as it stands once the current sdata bit is shifted in.
  assign word   = {shreg_q[BITSIZE-2:0], sdata_s};

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    bad_d     = bad_q;
    lr_prev_d = lr_prev_q;
    pend_d    = 1'b0;
    err_d     = 1'b0;

    if (bre) begin
      lr_prev_d = lrclk_s;
      unique case (state_q)
        ST_IDLE: begin
          // Only a left start can open the first pair after reset; any
          // right word seen before it is dropped.
          if (is_left_start(lr_prev_q, lrclk_s)) begin
            state_d = ST_SHIFT;
            ch_d    = CH_L;
            cnt_d   = '0;
            bad_d   = 1'b0;
          end
        end

        ST_SHIFT: begin
          if (lr_chg) begin
            // Word cut short. A cut left word spoils the right word that
            // follows; a cut right word ends its pair, and the new left
            // start begins a clean one.
            err_d   = 1'b1;
            ch_d    = lrclk_s;
            cnt_d   = '0;
            bad_d   = (lrclk_s == CH_R);
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_WAIT;
            if (ch_q == CH_L) begin
              hold_l_d = word;
            end else begin
              hold_r_d = word;
              pend_d   = ~bad_q;
            end
          end else begin
            shreg_d = word;
            cnt_d   = cnt_q + CW'(1);
          end
        end

        ST_WAIT: begin
          // Bits past BITSIZE in a wide slot are dropped here. The LR change
          // bre is the one-bit delay slot; the MSB follows on the next bre.
          if (lr_chg) begin
            state_d = ST_SHIFT;
            ch_d    = lrclk_s;
            cnt_d   = '0;
            if (lrclk_s == CH_L) begin
              bad_d = 1'b0;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The output copy runs one clk after hold_r is written so both words
  // change on the same edge as valid.
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    valid_d = pend_q;
    if (pend_q) begin
      left_d  = hold_l_q;
      right_d = hold_r_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= CH_L;
      cnt_q     <= '0;
      shreg_q   <= '0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      bad_q     <= 1'b0;
      lr_prev_q <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      bad_q     <= bad_d;
      lr_prev_q <= lr_prev_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
    end
  end

  assign left_chan  = left_q;
  assign right_chan = right_q;
  assign valid      = valid_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_i2s_rx_sync.sv
// Bench for i2s_rx_sync: a codec model drives 64-bclk stereo frames with
// clk = 16x bclk. Expected word pairs go into a scoreboard queue when a frame
// is driven; a monitor pops and compares on every valid pulse, checks that
// outputs never move without valid, counts frame_err pulses and, when enabled,
// checks valid-to-valid spacing.
module tb_i2s_rx_sync;

  localparam int BITSIZE     = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;              // clk cycles per bclk half period
  localparam int FRAME_CLKS  = 64 * 2 * HALF;  // 64 bclk per frame

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic               bclk  = 1'b0;
  logic               lrclk = 1'b0;
  logic               sdata = 1'b0;
  logic [BITSIZE-1:0] left_chan;
  logic [BITSIZE-1:0] right_chan;
  logic               valid;
  logic               frame_err;

  always #5 clk = ~clk;

  i2s_rx_sync #(.BITSIZE(BITSIZE), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .reset      (reset),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .left_chan  (left_chan),
    .right_chan (right_chan),
    .valid      (valid),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [31:0] l_data;
    int          l_bits;
    int          l_slot;
    logic [31:0] r_data;
    int          r_bits;
    int          r_slot;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    bit          exp_valid;
    int          exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  vec_t   vecs[7];
  pair_t  sb_q[$];
  pair_t  exp_pair;

  int     tests_run    = 0;
  int     tests_failed = 0;
  int     err_seen     = 0;
  int     err_exp      = 0;
  int     fail_prints  = 0;
  longint cyc          = 0;
  longint last_valid   = -1;
  bit     spacing_chk  = 1'b0;
  logic [15:0] prev_l  = '0;
  logic [15:0] prev_r  = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end else begin
      $display("[TB] ok %s = %h", name, got);
    end
  endtask

  // ------------------------------------------------------------ monitor
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (frame_err) err_seen++;
      if (valid) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_valid: got L=%h R=%h, required no valid", left_chan, right_chan);
        end else begin
          exp_pair = sb_q.pop_front();
          if (left_chan !== exp_pair.l || right_chan !== exp_pair.r) begin
            tests_failed++;
            $display("FAIL pair: got L=%h R=%h, required L=%h R=%h",
                     left_chan, right_chan, exp_pair.l, exp_pair.r);
          end else begin
            $display("[TB] valid L=%h R=%h matches", left_chan, right_chan);
          end
        end
        if (spacing_chk && last_valid >= 0) begin
          tests_run++;
          if (cyc - last_valid != FRAME_CLKS) begin
            tests_failed++;
            $display("FAIL valid_spacing: got %0d, required %0d", cyc - last_valid, FRAME_CLKS);
          end
        end
        last_valid = cyc;
      end else if (left_chan !== prev_l || right_chan !== prev_r) begin
        tests_run++;
        tests_failed++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL held_outputs: got L=%h R=%h without valid, required L=%h R=%h",
                   left_chan, right_chan, prev_l, prev_r);
        end
      end
    end
    prev_l = left_chan;
    prev_r = right_chan;
  end

  // ------------------------------------------------------------ codec model
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One channel slot. Period 0 is the delay slot after the LR change; data
  // runs MSB-first from period 1. Non-data bits are driven 1 so any bit the
  // receiver wrongly keeps shows up in the word.
  task automatic send_slot(input logic lr, input logic [31:0] data, input int nbits, input int slot);
    for (int i = 0; i < slot; i++) begin
      bclk  = 1'b0;
      lrclk = lr;
      if (i >= 1 && i <= nbits) sdata = data[nbits - i];
      else                      sdata = 1'b1;
      tick(HALF);
      bclk = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    sb_q.push_back('{l: l, r: r});
    send_slot(1'b0, {16'h0, l}, 16, 32);
    send_slot(1'b1, {16'h0, r}, 16, 32);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    vecs[0] = '{32'hABCDEF, 24, 32, 32'h123456, 24, 32, 16'hABCD, 16'h1234, 1'b1, 0};
    vecs[1] = '{32'hFFFF,   16, 11, 32'h4321,   16, 32, 16'h0000, 16'h0000, 1'b0, 1};
    vecs[2] = '{32'h55AA,   16, 32, 32'hAA55,   16, 32, 16'h55AA, 16'hAA55, 1'b1, 0};
    vecs[3] = '{32'h800000, 24, 32, 32'h7FFFFF, 24, 32, 16'h8000, 16'h7FFF, 1'b1, 0};
    vecs[4] = '{32'h1111,   16, 32, 32'h2222,   16, 11, 16'h0000, 16'h0000, 1'b0, 1};
    vecs[5] = '{32'h0001,   16, 32, 32'hFFFE,   16, 32, 16'h0001, 16'hFFFE, 1'b1, 0};
    vecs[6] = '{32'h76543210, 31, 32, 32'h0000, 16, 32, 16'hECA8, 16'h0000, 1'b1, 0};

    // Reset state
    #1 reset = 1'b0;
    tick(4);
    check("reset_left",  {16'h0, left_chan},  32'h0);
    check("reset_right", {16'h0, right_chan}, 32'h0);
    check("reset_valid", {31'h0, valid},      32'h0);
    check("reset_err",   {31'h0, frame_err},  32'h0);
    reset = 1'b1;
    tick(3);

    // Start mid-right: a full right word before any left start yields nothing.
    send_slot(1'b1, 32'h1234, 16, 32);
    check("no_valid_right_first", sb_q.size(), 0);

    // Basic frames
    send_pair(16'h8001, 16'h7FFE);
    send_pair(16'h8001, 16'h7FFE);
    check("err_after_basic", err_seen, err_exp);

    // Reset halfway through the right word of frame 2
    send_pair(16'h8001, 16'h7FFE);
    send_slot(1'b0, 32'h8001, 16, 32);
    send_slot(1'b1, 32'h7FFE, 16, 9);
    check("pre_reset_left", {16'h0, left_chan}, 32'h8001);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_left",  {16'h0, left_chan},  32'h0);
    check("mid_reset_right", {16'h0, right_chan}, 32'h0);
    check("mid_reset_valid", {31'h0, valid},      32'h0);
    tick(5);
    reset = 1'b1;
    send_slot(1'b1, 32'h0, 0, 23);
    check("no_valid_after_reset", sb_q.size(), 0);
    send_pair(16'hC3A5, 16'h5A3C);
    check("err_after_reset", err_seen, err_exp);

    // Table: wide slots, truncated left, truncated right, width cases
    foreach (vecs[k]) begin
      if (vecs[k].exp_valid) sb_q.push_back('{l: vecs[k].exp_l, r: vecs[k].exp_r});
      err_exp += vecs[k].exp_err;
      send_slot(1'b0, vecs[k].l_data, vecs[k].l_bits, vecs[k].l_slot);
      send_slot(1'b1, vecs[k].r_data, vecs[k].r_bits, vecs[k].r_slot);
    end
    check("err_after_table", err_seen, err_exp);
    check("sb_after_table", sb_q.size(), 0);

    // Alternating full-scale words with constant spacing
    spacing_chk = 1'b1;
    last_valid  = -1;
    for (int f = 0; f < 40; f++) begin
      if (f % 2 == 0) send_pair(16'hFFFF, 16'h0000);
      else            send_pair(16'h0000, 16'hFFFF);
    end
    spacing_chk = 1'b0;

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick(1);
    check("sb_drained", sb_q.size(), 0);
    check("err_final", err_seen, err_exp);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
